mem_read_arbiter: RTL

Shares one synchronous memory read port between `NUM_REQ` router controllers using round-robin arbitration. On each grant it issues a fixed-length burst of consecutive reads, starting at the winner's source address, and streams the returned words back tagged with the owner. It sits between the per-port router controllers (`arbiter_read_req`/`arbiter_read_gnt`/`arbiter_src_addr`) and the packet memory feeding the encode path.

---
 rtl/router_pkg.sv | 21 ++
 rtl/mem_read_arbiter_if.sv | 29 ++
 rtl/rr_picker.sv | 32 +++
 rtl/mem_read_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: arbiter FSM encoding, default bus and packet
// dimensions, and the beat-counter sizing helper.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUMBER_PACKET  = 19;

  // Width of a counter that holds beat indices 0..burst_len-1.
  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Request/grant, memory read port and return stream of the shared read arbiter.
// master = the arbiter, slave = requesters plus the memory.
interface mem_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = router_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH_DEF
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic                          busy;
  logic                          mem_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_rd_addr;
  logic [DATA_WIDTH-1:0]         mem_rd_data;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          rd_valid;
  logic                          rd_last;
  logic [NUM_REQ-1:0]            rd_owner;

  modport master (
    input  req, req_addr, mem_rd_data,
    output gnt, busy, mem_rd_en, mem_rd_addr, rd_data, rd_valid, rd_last, rd_owner
  );

  modport slave (
    output req, req_addr, mem_rd_data,
    input  gnt, busy, mem_rd_en, mem_rd_addr, rd_data, rd_valid, rd_last, rd_owner
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping modulo NUM_REQ, wins. Shared with the output-port arbitration.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_any
);

  // Scan upward from the pointer and keep the first hit.
  always_comb begin
    int j;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_any && req[j]) begin
        win_any    = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin owner of the packet-memory read port. Each grant issues a
// BURST_LEN-word burst of consecutive reads and returns the words, tagged
// with the owner, two cycles after each read strobe.
module mem_read_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = NUMBER_PACKET
) (
  input logic                clk,
  input logic                rst,
  mem_read_arbiter_if.master bus
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = beat_cnt_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_t              state;
  logic [IDX_W-1:0]        ptr;
  logic [NUM_REQ-1:0]      win_oh;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_any;
  logic [BEAT_W-1:0]       beat;
  logic                    drain_cnt;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [NUM_REQ-1:0]      owner_q;
  logic                    busy_q;

  logic                    rd_en_p0;
  logic                    last_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;

  logic                    vld_p1;
  logic                    last_p1;
  logic [NUM_REQ-1:0]      own_p1;

  logic                    vld_p2;
  logic                    last_p2;
  logic [NUM_REQ-1:0]      own_p2;
  logic [DATA_WIDTH-1:0]   data_p2;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req     (bus.req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Arbitration FSM; also issues the read strobe/address stream (stage p0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      beat      <= '0;
      drain_cnt <= 1'b0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      rd_en_p0  <= 1'b0;
      last_p0   <= 1'b0;
      addr_p0   <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            state    <= ST_GRANT;
            gnt_q    <= win_oh;
            owner_q  <= win_oh;
            busy_q   <= 1'b1;
            rd_en_p0 <= 1'b1;
            last_p0  <= 1'b0;
            addr_p0  <= bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ptr      <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
          end
        end
        ST_GRANT: begin
          state   <= ST_BURST;
          beat    <= BEAT_W'(1);
          addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
          last_p0 <= (LAST_BEAT == BEAT_W'(1));
        end
        ST_BURST: begin
          if (beat == LAST_BEAT) begin
            state     <= ST_DRAIN;
            rd_en_p0  <= 1'b0;
            last_p0   <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            beat    <= beat + BEAT_W'(1);
            addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
            last_p0 <= ((beat + BEAT_W'(1)) == LAST_BEAT);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Return path: p1 tracks the memory access cycle, p2 registers the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      own_p1  <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      own_p2  <= '0;
      data_p2 <= '0;
    end else begin
      vld_p1  <= rd_en_p0;
      last_p1 <= rd_en_p0 & last_p0;
      own_p1  <= rd_en_p0 ? owner_q : '0;
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 & last_p1;
      own_p2  <= own_p1;
      data_p2 <= bus.mem_rd_data;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.mem_rd_en   = rd_en_p0;
  assign bus.mem_rd_addr = addr_p0;
  assign bus.rd_data     = data_p2;
  assign bus.rd_valid    = vld_p2;
  assign bus.rd_last     = last_p2;
  assign bus.rd_owner    = own_p2;

endmodule
